// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: queues ALU requests in a small FIFO, drives the combinational
// ALU from the FIFO head and captures result/flags into a registered output
// stage. Both sides use valid/ready handshakes so requester and consumer can
// stall independently. Up to DEPTH+1 results can be in flight.
module alu_issue_ctrl #(
  parameter int DW    = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic [3:0]    in_tag,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_control,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_zero,
  input  logic          alu_lt,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_result,
  output logic          out_zero,
  output logic          out_lt,
  output logic [3:0]    out_tag,
  output logic [AW:0]   count,
  output logic [15:0]   done_cnt
);

  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  logic [2:0]    opMem_q  [DEPTH];
  logic [DW-1:0] aMem_q   [DEPTH];
  logic [DW-1:0] bMem_q   [DEPTH];
  logic [3:0]    tagMem_q [DEPTH];

  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [AW:0]   count_q, count_d;
  logic          outValid_q, outValid_d;
  logic [DW-1:0] outResult_q, outResult_d;
  logic          outZero_q, outZero_d;
  logic          outLt_q, outLt_d;
  logic [3:0]    outTag_q, outTag_d;
  logic [15:0]   doneCnt_q, doneCnt_d;

  logic notEmpty;
  logic push;
  logic pop;
  logic handshake;

  // in_ready looks only at the registered count, so a full FIFO never takes a
  // push even in a cycle where it also pops.
  assign notEmpty  = (count_q != '0);
  assign in_ready  = (count_q < FullCount);
  assign push      = in_valid && in_ready;
  assign pop       = notEmpty && (!outValid_q || out_ready);
  assign handshake = outValid_q && out_ready;

  assign out_valid  = outValid_q;
  assign out_result = outResult_q;
  assign out_zero   = outZero_q;
  assign out_lt     = outLt_q;
  assign out_tag    = outTag_q;
  assign count      = count_q;
  assign done_cnt   = doneCnt_q;

  // Present the head entry to the ALU; idle value is "pass a" with zero operands.
  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_control = 3'b111;
    if (notEmpty) begin
      alu_a       = aMem_q[rdPtr_q];
      alu_b       = bMem_q[rdPtr_q];
      alu_control = opMem_q[rdPtr_q];
    end
  end

  // Next-state for pointers, occupancy, output stage and delivered-result count.
  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    count_d     = count_q;
    outValid_d  = outValid_q;
    outResult_d = outResult_q;
    outZero_d   = outZero_q;
    outLt_d     = outLt_q;
    outTag_d    = outTag_q;
    doneCnt_d   = doneCnt_q;
    if (flush) begin
      wrPtr_d    = '0;
      rdPtr_d    = '0;
      count_d    = '0;
      outValid_d = 1'b0;
    end else begin
      if (push) begin
        wrPtr_d = wrPtr_q + AW'(1);
      end
      if (pop) begin
        rdPtr_d = rdPtr_q + AW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + (AW+1)'(1);
      end else if (!push && pop) begin
        count_d = count_q - (AW+1)'(1);
      end
      if (pop) begin
        outValid_d  = 1'b1;
        outResult_d = alu_result;
        outZero_d   = alu_zero;
        outLt_d     = alu_lt;
        outTag_d    = tagMem_q[rdPtr_q];
      end else if (handshake) begin
        outValid_d = 1'b0;
      end
      if (handshake) begin
        doneCnt_d = doneCnt_q + 16'd1;
      end
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      outValid_q  <= 1'b0;
      outResult_q <= '0;
      outZero_q   <= 1'b0;
      outLt_q     <= 1'b0;
      outTag_q    <= '0;
      doneCnt_q   <= '0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      outValid_q  <= outValid_d;
      outResult_q <= outResult_d;
      outZero_q   <= outZero_d;
      outLt_q     <= outLt_d;
      outTag_q    <= outTag_d;
      doneCnt_q   <= doneCnt_d;
    end
  end

  // FIFO storage needs no reset; a write is dropped under reset or flush.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && push) begin
      opMem_q[wrPtr_q]  <= in_op;
      aMem_q[wrPtr_q]   <= in_a;
      bMem_q[wrPtr_q]   <= in_b;
      tagMem_q[wrPtr_q] <= in_tag;
    end
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the 16-bit ALU interface: queues operation requests, drives the ALU operand/function ports, and samples result/zero/lt into a registered output stage.
- Sits between the decode/operand-fetch logic and the combinational ALU, decoupling them with valid/ready handshakes so the requester can stall independently of the consumer.

Parameters:
- DW, 16, operand/result width; must match the ALU data width.
- DEPTH, 4, request FIFO entries; power of two, minimum 2.
- AW, 2, log2(DEPTH); pointer width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  synchronous clear of queued requests and the output stage.
- in_valid  in  1  request valid.
- in_ready  out  1  FIFO can accept a request.
- in_op  in  3  ALU function select: 000 add, 001 sub, 010 popcount of a[3:0]^b[3:0], 011 xor, 100 shift right, 101 and, 110 or, 111 pass a.
- in_a  in  DW  source operand 1.
- in_b  in  DW  source operand 2.
- in_tag  in  4  requester tag, returned unchanged with the result.
- alu_a  out  DW  to ALU a.
- alu_b  out  DW  to ALU b.
- alu_control  out  3  to ALU alu_control.
- alu_result  in  DW  from ALU result.
- alu_zero  in  1  from ALU zero.
- alu_lt  in  1  from ALU lt.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  DW  captured result.
- out_zero  out  1  captured zero flag.
- out_lt  out  1  captured lt flag.
- out_tag  out  4  tag of the captured result.
- count  out  AW+1  FIFO occupancy, 0 to DEPTH.
- done_cnt  out  16  results delivered since reset; wraps 0xFFFF to 0x0000.

Behaviour:
- Reset (rst_n=0 at an edge): clear FIFO pointers. count=0, out_valid=0, out_result=0, out_zero=0, out_lt=0, out_tag=0, done_cnt=0. Reset mid-operation discards all queued and held results with no partial output.
- Push: when in_valid && in_ready, write {op,a,b,tag} at the write pointer. in_ready = (count < DEPTH). It depends only on registered count; no same-cycle full bypass, so a full FIFO refuses a push even when a pop occurs in that cycle.
- ALU drive: combinational from the FIFO head entry when count>0. When count==0, drive alu_a=0, alu_b=0, alu_control=3'b111.
- Capture condition: cap = (count>0) && (!out_valid || out_ready).
  - When cap is true: pop the head and register alu_result, alu_zero, alu_lt and the head tag into the out_* regs; set out_valid=1.
  - Else if out_valid && out_ready: out_valid=0.
- Output stability: out_* hold stable while out_valid && !out_ready.
- Latency: a request accepted at edge N into an empty block appears with out_valid=1 after edge N+1 (2 cycles). Sustained throughput is 1 result/cycle when out_ready=1.
- Simultaneous push and pop: count unchanged; pointers wrap modulo DEPTH.
- Push into empty FIFO: the entry cannot be popped in the same cycle (no bypass).
- done_cnt: increments by 1 on each out_valid && out_ready handshake; 16-bit wrap.
- flush=1: same-edge effect as reset on count, pointers and out_valid. done_cnt and out_* data are not cleared. Any push or handshake in that cycle is ignored.
- Priority: rst_n over flush over normal operation.
- Total capacity: DEPTH+1 results in flight (FIFO plus the output register).

Test Plan:
- Single add: op=000, a=0x7FFF, b=0x0001, tag=3, out_ready=1. Required: out_valid 2 cycles after acceptance with out_result=0x8000, zero=0, lt=1, tag=3; done_cnt=1.
- Sub and popcount back-to-back, one per cycle: op=001, a=b=0x0005, then op=010, a=0x000F, b=0x0000. Required: consecutive results 0x0000 (zero=1), then 0x0004 (zero=0); count never exceeds 1.
- Backpressure: out_ready=0, in_valid held high. Required: exactly 5 requests accepted, count=4, in_ready=0, out_* hold the first result stable. Raise out_ready: results drain in order, tags 0..4.
- Simultaneous push/pop at full: count=4, out_ready=1, in_valid=1. Required: no push that cycle (in_ready=0); count goes 4 to 3; the push is accepted on the next cycle.
- Flush with 3 queued and out_valid=1: assert flush one cycle. Required: next cycle count=0, out_valid=0, alu_control=111, done_cnt unchanged.
- Reset mid-stream: rst_n=0 for one edge while 2 are queued. Required: all outputs at reset values and in_ready=1. A new request afterwards (op=111, a=0x1234) returns out_result=0x1234.
